// File: rtl/gf2_poly_pkg.sv
// Shared widths, state encoding and helpers for the GF(2)[x] divider family.
package gf2_poly_pkg;

    localparam int N_DEF   = 521;
    localparam int DVD_DEF = 2 * N_DEF;

    // Degree register width; a 1-bit divisor still needs a 1-bit register.
    function automatic int deg_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DW_DEF = deg_w(N_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gf2_msb_index.sv
// Combinational priority encoder: position of the highest set bit of b, plus a zero flag.
module gf2_msb_index
    import gf2_poly_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = deg_w(N)
) (
    input  logic [N-1:0]  b,
    output logic [DW-1:0] idx,
    output logic          zero
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) idx = DW'(i);
        end
    end

    assign zero = ~|b;

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial carry-less long divider: 2N-bit dividend / N-bit divisor, one dividend bit per clock.
module gf2_poly_divider
    import gf2_poly_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = deg_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           div_zero,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r
);

    localparam int CW = $clog2(2 * N);

    state_e          state_q;
    logic [2*N-1:0]  dvd_q;
    logic [N-1:0]    dvs_q;
    logic [DW-1:0]   deg_q;
    logic [N-1:0]    rem_q;
    logic [2*N-1:0]  q_q;
    logic [CW-1:0]   cnt_q;
    logic            div_zero_q;

    logic [DW-1:0]   b_msb;
    logic            b_zero;
    logic [N:0]      step_t;
    logic            qbit_d;
    logic [N-1:0]    rem_d;

    gf2_msb_index #(.N(N), .DW(DW)) u_msb (
        .b    (b),
        .idx  (b_msb),
        .zero (b_zero)
    );

    // deg(rem) < deg(divisor) keeps step_t[N] at zero, so only the low N bits are carried.
    always_comb begin
        step_t = {rem_q, dvd_q[2*N-1]};
        qbit_d = step_t[deg_q];
        rem_d  = qbit_d ? (step_t[N-1:0] ^ dvs_q) : step_t[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            deg_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q <= '0;
                        q_q   <= '0;
                        if (b_zero) begin
                            div_zero_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            dvd_q      <= a;
                            dvs_q      <= b;
                            deg_q      <= b_msb;
                            cnt_q      <= CW'(2 * N - 1);
                            div_zero_q <= 1'b0;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= {dvd_q[2*N-2:0], 1'b0};
                    rem_q <= rem_d;
                    q_q   <= {q_q[2*N-2:0], qbit_d};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);
    assign div_zero = div_zero_q;
    assign q        = q_q;
    assign r        = rem_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and randomized checks of gf2_poly_divider at N=8 and N=521 against a textbook long-division model.
module tb_gf2_poly_divider;

    localparam int W = 1042;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [15:0] a8;
    logic [7:0]  b8;
    logic        busy8, done8, dz8;
    logic [15:0] q8;
    logic [7:0]  r8;

    logic           start521;
    logic [1041:0]  a521;
    logic [520:0]   b521;
    logic           busy521, done521, dz521;
    logic [1041:0]  q521;
    logic [520:0]   r521;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    gf2_poly_divider #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .q(q8), .r(r8)
    );

    gf2_poly_divider #(.N(521)) dut521 (
        .clk(clk), .rst(rst), .start(start521), .a(a521), .b(b521),
        .busy(busy521), .done(done521), .div_zero(dz521), .q(q521), .r(r521)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    // Schoolbook division: cancel the top set bit of the running remainder with a shifted divisor.
    function automatic void ref_div(input logic [W-1:0] av, input logic [W-1:0] bv, input int n,
                                    output logic [W-1:0] qv, output logic [W-1:0] rv);
        int db = 0;
        for (int i = 0; i < n; i++) if (bv[i]) db = i;
        rv = av;
        qv = '0;
        for (int i = 2 * n - 1; i >= db; i--) begin
            if (rv[i]) begin
                rv ^= bv << (i - db);
                qv[i - db] = 1'b1;
            end
        end
    endfunction

    function automatic logic [W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y, input int n);
        logic [W-1:0] p = '0;
        for (int i = 0; i < 2 * n; i++) if (x[i]) p ^= y << i;
        return p;
    endfunction

    // Issue one start edge and count edges until done is seen.
    task automatic go8(input logic [15:0] av, input logic [7:0] bv, output int lat, output int bcnt);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat  = 0;
        bcnt = busy8 ? 1 : 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy8) bcnt++;
        end
    endtask

    task automatic go521(input logic [1041:0] av, input logic [520:0] bv, output int lat);
        a521 = av; b521 = bv; start521 = 1'b1;
        @(posedge clk); #1;
        start521 = 1'b0;
        lat = 0;
        while (!done521 && lat < 1200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic dir8(input string tag, input logic [15:0] av, input logic [7:0] bv,
                        input logic [15:0] qe, input logic [7:0] re);
        int lat, bcnt;
        go8(av, bv, lat, bcnt);
        chk({tag, ".lat"}, lat, 16);
        chk({tag, ".busy_cycles"}, bcnt, 16);
        chk({tag, ".q"}, q8, qe);
        chk({tag, ".r"}, r8, re);
        chk({tag, ".div_zero"}, dz8, 1'b0);
        @(posedge clk); #1;
        chk({tag, ".done_one_cycle"}, done8, 1'b0);
        chk({tag, ".q_hold"}, q8, qe);
    endtask

    initial begin
        int lat, bcnt;
        logic [W-1:0] qe, re;
        logic [1041:0] ra;
        logic [520:0]  rb;

        rst = 1'b1; start8 = 1'b0; start521 = 1'b0;
        a8 = '0; b8 = '0; a521 = '0; b521 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", busy8, 1'b0);
        chk("rst.done", done8, 1'b0);
        chk("rst.dz", dz8, 1'b0);
        chk("rst.q", q8, 16'h0);
        chk("rst.r", r8, 8'h0);
        chk("rst.q521", q521, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        dir8("exact", 16'h0027, 8'h0B, 16'h0005, 8'h00);
        dir8("rem3", 16'h0024, 8'h0B, 16'h0005, 8'h03);
        dir8("b80", 16'hFFFF, 8'h80, 16'h01FF, 8'h7F);
        dir8("b01", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00);

        go8(16'h1234, 8'h00, lat, bcnt);
        chk("zero.lat", lat, 0);
        chk("zero.dz", dz8, 1'b1);
        chk("zero.q", q8, 16'h0);
        chk("zero.r", r8, 8'h0);
        @(posedge clk); #1;
        chk("zero.done_one_cycle", done8, 1'b0);

        // A second start during CALC must not disturb the running operation.
        a8 = 16'h0024; b8 = 8'h0B; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        a8 = 16'hFFFF; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        lat++;
        start8 = 1'b0;
        while (!done8 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("ign.lat", lat, 16);
        chk("ign.q", q8, 16'h0005);
        chk("ign.r", r8, 8'h03);
        chk("ign.dz", dz8, 1'b0);
        @(posedge clk); #1;

        // Reset sampled on the seventh CALC edge.
        a8 = 16'h0027; b8 = 8'h0B; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.busy", busy8, 1'b0);
        chk("midrst.done", done8, 1'b0);
        chk("midrst.q", q8, 16'h0);
        chk("midrst.r", r8, 8'h0);
        dir8("postrst", 16'h0027, 8'h0B, 16'h0005, 8'h00);

        for (int k = 0; k < 150; k++) begin
            logic [15:0] av;
            logic [7:0]  bv;
            av = 16'($urandom);
            bv = 8'($urandom) >> $urandom_range(0, 7);
            if (bv == 8'h00) bv = 8'h01;
            go8(av, bv, lat, bcnt);
            ref_div(W'(av), W'(bv), 8, qe, re);
            chk("r8.lat", lat, 16);
            chk("r8.q", q8, qe);
            chk("r8.r", r8, re);
            chk("r8.ident", clmul(W'(q8), W'(b8), 8) ^ W'(r8), W'(av));
            @(posedge clk); #1;
        end

        for (int k = 0; k < 25; k++) begin
            for (int w = 0; w < 33; w++) ra[w*32 +: 32] = $urandom;
            rb = '0;
            for (int w = 0; w < 17; w++) rb[w*32 +: 32] = $urandom;
            rb = rb >> $urandom_range(0, 520);
            if (k == 0) rb = 521'd1;
            if (k == 1) begin rb = '0; rb[520] = 1'b1; end
            if (rb == '0) rb = 521'd3;
            go521(ra, rb, lat);
            ref_div(ra, W'(rb), 521, qe, re);
            chk("r521.lat", lat, 1042);
            chk("r521.dz", dz521, 1'b0);
            chk("r521.q", q521, qe);
            chk("r521.r", r521, re);
            chk("r521.ident", clmul(q521, W'(r521) ^ W'(r521) ^ W'(rb), 521) ^ W'(r521), ra);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
